// File: rtl/frac_clk_div_if.sv
// Configuration channel for frac_clk_div: ratio request (valid/ready) plus
// the rejection pulse returned by the divider.
interface frac_clk_div_if #(
  parameter int WIDTH = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_mul;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_mul, cfg_div, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_mul, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/frac_clk_div.sv
// Rational M/N clock-enable generator: phase accumulator emitting a one-cycle
// strobe at f_clk*M/N, a half-rate clk_out and a lock flag after settling.
module frac_clk_div #(
  parameter int WIDTH       = 16,
  parameter int LOCK_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  frac_clk_div_if.slave  cfg,
  input  logic           enable,
  output logic           strobe,
  output logic           clk_out,
  output logic           locked
);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mul_q, mul_d, div_q, div_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             strobe_q, strobe_d, clk_out_q, clk_out_d;
  logic             locked_q, locked_d, err_q, err_d;
  logic [WIDTH:0]   sum;
  logic             xfer, cfg_ok;

  always_comb begin
    state_d   = state_q;
    mul_d     = mul_q;
    div_d     = div_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    strobe_d  = 1'b0;
    clk_out_d = clk_out_q;
    err_d     = 1'b0;
    sum       = {1'b0, acc_q} + {1'b0, mul_q};
    xfer      = cfg.cfg_valid && (state_q != ST_LOAD);
    cfg_ok    = (cfg.cfg_mul != '0) && (cfg.cfg_div != '0) && (cfg.cfg_mul <= cfg.cfg_div);

    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: state_d = enable ? ST_RUN : ST_HOLD;
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_HOLD;
        end else if (sum >= {1'b0, div_q}) begin
          // acc < div keeps acc + mul - div inside WIDTH bits
          acc_d     = acc_q + mul_q - div_q;
          strobe_d  = 1'b1;
          clk_out_d = ~clk_out_q;
          if (cnt_q != LOCK_MAX) cnt_d = cnt_q + CW'(1);
        end else begin
          acc_d = sum[WIDTH-1:0];
        end
      end
      ST_HOLD: if (enable) state_d = ST_RUN;
    endcase

    locked_d = locked_q | (cnt_d == LOCK_MAX);

    // Clearing on entry to LOAD makes the outputs read zero during LOAD itself.
    if (xfer) begin
      if (cfg_ok) begin
        state_d   = ST_LOAD;
        mul_d     = cfg.cfg_mul;
        div_d     = cfg.cfg_div;
        acc_d     = '0;
        cnt_d     = '0;
        strobe_d  = 1'b0;
        clk_out_d = 1'b0;
        locked_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mul_q     <= '0;
      div_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      clk_out_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_q     <= mul_d;
      div_q     <= div_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
      clk_out_q <= clk_out_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign cfg.cfg_ready = (state_q != ST_LOAD);
  assign cfg.cfg_err   = err_q;
  assign strobe        = strobe_q;
  assign clk_out       = clk_out_q;
  assign locked        = locked_q;
endmodule

// File: tb/tb_frac_clk_div.sv
// Self-checking bench for frac_clk_div: a ratio-level model (strobe count after
// k run steps = floor(k*M/N)) checked every cycle, plus directed literal checks.
module tb_frac_clk_div;
  localparam int WIDTH = 16;
  localparam int LOCK  = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HOLD = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic strobe, clk_out, locked;

  int checks = 0;
  int errors = 0;

  frac_clk_div_if #(.WIDTH(WIDTH)) cfg_if ();

  frac_clk_div #(.WIDTH(WIDTH), .LOCK_CYCLES(LOCK)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg    (cfg_if),
    .enable (enable),
    .strobe (strobe),
    .clk_out(clk_out),
    .locked (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int     mode;
    int     mul;
    int     div;
    longint k;     // run steps since the last load
    int     cnt;   // strobes since the last load
    logic   stb;
    logic   err;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t step(mdl_t s, logic v, logic [WIDTH-1:0] mm,
                                logic [WIDTH-1:0] dd, logic en);
    mdl_t n = s;
    n.stb = 1'b0;
    n.err = 1'b0;
    if (v && s.mode != M_LOAD) begin
      if (mm != 0 && dd != 0 && mm <= dd) begin
        n.mode = M_LOAD; n.mul = int'(mm); n.div = int'(dd); n.k = 0; n.cnt = 0;
        return n;
      end
      n.err = 1'b1;
    end
    case (s.mode)
      M_LOAD: n.mode = en ? M_RUN : M_HOLD;
      M_RUN: begin
        if (!en) n.mode = M_HOLD;
        else begin
          n.k = s.k + 1;
          if ((n.k * s.mul) / s.div != (s.k * s.mul) / s.div) begin
            n.stb = 1'b1;
            n.cnt = s.cnt + 1;
          end
        end
      end
      M_HOLD: if (en) n.mode = M_RUN;
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, cfg_if.cfg_valid, cfg_if.cfg_mul, cfg_if.cfg_div, enable);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("strobe",    32'(strobe),           32'(m.stb));
    chk("clk_out",   32'(clk_out),          32'(m.cnt[0]));
    chk("locked",    32'(locked),           32'(m.cnt >= LOCK));
    chk("cfg_err",   32'(cfg_if.cfg_err),   32'(m.err));
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m.mode != M_LOAD));
  end

  task automatic send_cfg(input int mm, input int dd);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mul   = WIDTH'(mm);
    cfg_if.cfg_div   = WIDTH'(dd);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Negedges until strobe is seen, -1 if the bound expires.
  task automatic wait_strobe(input int lim, output int n);
    bit seen = 0;
    n = -1;
    for (int i = 1; i <= lim && !seen; i++) begin
      @(negedge clk);
      if (strobe) begin n = i; seen = 1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, last, bad, errs;
    logic co, lk;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mul   = '0;
    cfg_if.cfg_div   = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
    chk("rst_clk_out", 32'(clk_out), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    cnt = 0;
    repeat (100) begin @(negedge clk); cnt += int'(strobe); end
    chk("idle_no_strobe", cnt, 0);

    // Integer divide 1/4
    send_cfg(1, 4);
    chk("load_ready_low", 32'(cfg_if.cfg_ready), 0);
    wait_strobe(40, n); chk("first_strobe_1_4", n, 5);
    chk("clk_out_first", 32'(clk_out), 1);
    wait_strobe(40, n); chk("gap2_1_4", n, 4);
    chk("clk_out_second", 32'(clk_out), 0);
    wait_strobe(40, n); chk("gap3_1_4", n, 4);
    chk("unlocked_at_3", 32'(locked), 0);
    wait_strobe(40, n); chk("gap4_1_4", n, 4);
    chk("locked_at_4", 32'(locked), 1);

    // Rejected configurations while running
    errs = 0;
    send_cfg(5, 4); errs += int'(cfg_if.cfg_err);
    send_cfg(0, 4); errs += int'(cfg_if.cfg_err);
    send_cfg(2, 0); errs += int'(cfg_if.cfg_err);
    chk("reject_err_count", errs, 3);
    chk("reject_locked", 32'(locked), 1);
    wait_strobe(40, n);
    wait_strobe(40, n); chk("reject_gap", n, 4);

    // Hold for 10 cycles, then resume phase
    enable = 1'b0;
    co = clk_out; lk = locked; cnt = 0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(strobe);
      if (clk_out !== co || locked !== lk) bad++;
    end
    chk("hold_no_strobe", cnt, 0);
    chk("hold_frozen", bad, 0);
    enable = 1'b1;
    wait_strobe(40, n); chk("hold_resume_phase", n, 5);

    // Reconfigure to 1/2 while running
    send_cfg(1, 2);
    chk("reload_ready_low", 32'(cfg_if.cfg_ready), 0);
    chk("reload_locked_clr", 32'(locked), 0);
    wait_strobe(40, n); chk("first_strobe_1_2", n, 3);
    wait_strobe(40, n); chk("gap_1_2", n, 2);

    // Fractional 3/8 over 800 run steps, random enable-free stretch
    send_cfg(3, 8);
    @(negedge clk);
    cnt = 0; last = -1; bad = 0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (strobe) begin
        cnt++;
        if (last >= 0 && (i - last < 2 || i - last > 3)) bad++;
        last = i;
      end
    end
    chk("frac_count", cnt, 300);
    chk("frac_spacing", bad, 0);

    // Random ratios with random enable toggling, checked by the model
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      send_cfg(n, n + int'($urandom_range(0, 40)));
      for (int c = 0; c < 150; c++) begin
        enable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) begin
          cfg_if.cfg_valid = 1'b1;
          cfg_if.cfg_mul = WIDTH'($urandom_range(0, 50));
          cfg_if.cfg_div = WIDTH'($urandom_range(0, 50));
        end else begin
          cfg_if.cfg_valid = 1'b0;
        end
        @(negedge clk);
      end
      cfg_if.cfg_valid = 1'b0;
      enable = 1'b1;
    end

    // Asynchronous reset mid-run on 3/8
    send_cfg(3, 8);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_strobe", 32'(strobe), 0);
    chk("async_clk_out", 32'(clk_out), 0);
    chk("async_locked", 32'(locked), 0);
    chk("async_ready", 32'(cfg_if.cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (50) begin @(negedge clk); cnt += int'(strobe); end
    chk("post_reset_idle", cnt, 0);
    send_cfg(1, 4);
    wait_strobe(40, n); chk("post_reset_reload", n, 5);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frac_clk_div.md
# frac_clk_div

Rational clock-enable generator that divides the system clock by M/N. It produces a one-cycle `strobe` at f_clk·M/N and a derived `clk_out` square wave at half that rate. The block sits downstream of the PLL, in the PLL output clock domain, and produces the slower sample/baseband rates for the FM datapath. Its `locked` flag indicates the divider has settled after a (re)configuration.

## Interface
- WIDTH, 16, width of the M (`cfg_mul`) and N (`cfg_div`) ratio terms
- LOCK_CYCLES, 4, number of strobes after a load before `locked` asserts (≥1)

- clk  in  1  system clock (PLL output)
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  block can accept configuration
- cfg_mul  in  WIDTH  M term of ratio
- cfg_div  in  WIDTH  N term of ratio
- enable  in  1  run/hold control
- strobe  out  1  one-cycle rate enable
- clk_out  out  1  toggles on every strobe
- locked  out  1  LOCK_CYCLES strobes seen since last load
- cfg_err  out  1  one-cycle pulse: configuration rejected

## Operation
- Registers: `mul`, `div` (WIDTH), `acc` (WIDTH), lock counter (clog2(LOCK_CYCLES+1)).
- States:
  - IDLE: no valid config since reset.
  - LOAD: one cycle.
  - RUN.
  - HOLD.
- Handshake:
  - `cfg_ready` = 1 in IDLE/RUN/HOLD and 0 in LOAD.
  - Transfer occurs on a clock edge with `cfg_valid && cfg_ready`.
- Validity: a transfer is accepted only if `cfg_mul != 0`, `cfg_div != 0` and `cfg_mul <= cfg_div`.
  - Invalid transfer: `cfg_err` = 1 for the next cycle. Registers and state are unchanged, and the running output continues undisturbed.
- Accepted transfer:
  - Latch `mul` and `div`, then enter LOAD.
  - LOAD clears `acc`, `strobe`, `clk_out`, `locked` and the lock counter.
  - LOAD → RUN if `enable`, else → HOLD.
- RUN, every cycle: sum = acc + mul, computed in WIDTH+1 bits.
  - If sum ≥ div: acc ← sum − div; strobe ← 1; clk_out ← ~clk_out; lock counter increments, saturating at LOCK_CYCLES.
  - Otherwise: acc ← sum; strobe ← 0.
  - `acc < div` holds at all times, so the result never overflows.
- `locked` ← 1 when the lock counter reaches LOCK_CYCLES. It stays high until the next LOAD or reset.
- RUN → HOLD when `enable` = 0. HOLD → RUN when `enable` = 1.
- HOLD: `acc`, `clk_out`, `locked` and the lock counter are frozen; `strobe` = 0.
- IDLE: `enable` is ignored and all outputs hold their reset values.
- A transfer in RUN/HOLD takes priority over enable; the next state is LOAD.
- mul = div: `strobe` is high on every cycle after the first RUN cycle, and `clk_out` = f_clk/2.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): state = IDLE.
  - `strobe` = 0, `clk_out` = 0, `locked` = 0, `cfg_err` = 0, `cfg_ready` = 1.
  - `acc`, `mul`, `div` = 0.
- Reset mid-operation returns to IDLE immediately. Outputs are forced to their reset values in the same cycle (asynchronous).
- `strobe`, `clk_out`, `locked` and `cfg_err` are registered outputs.
- Strobe latency: `strobe` is high in the cycle after the RUN cycle in which sum ≥ div.
- Transfer at edge t:
  - LOAD occupies cycle t+1.
  - The first RUN cycle is t+2.
  - With mul = 1 and div = N, the first `strobe` is high in cycle t+2+N.
  - Subsequent strobes have period exactly N.
- The long-run strobe count is exactly M per N RUN cycles. The spacing between strobes never differs by more than 1 cycle from ceil or floor of N/M.
- The `cfg_err` pulse appears in the cycle after the rejected transfer edge.
- The `enable` deassert takes effect on the next edge. At most one strobe already in flight (registered) is still visible.

## Test plan
- Reset:
  - Hold `rst_n` = 0, then release it.
  - Required: all outputs at reset values, `cfg_ready` = 1, and no strobe for 100 cycles with `enable` = 1 and no config.
- Integer divide:
  - Load mul = 1, div = 4, `enable` = 1.
  - Required:
    - First strobe 4 cycles after the first RUN cycle, then every 4 cycles.
    - `clk_out` period is 8 cycles.
    - `locked` rises with the 4th strobe.
- Fractional divide:
  - Load mul = 3, div = 8 and run 800 cycles.
  - Required:
    - Exactly 300 strobes.
    - Spacing always 2 or 3 cycles.
    - `acc` < 8 at all times.
- Rejected config:
  - While running 1/4, send (5, 4), then (0, 4), then (2, 0).
  - Required: `cfg_err` pulses once each, the strobe period stays 4, and `locked` stays 1.
- Hold and reconfigure:
  - Drop `enable` for 10 cycles mid-run.
  - Required: no strobes, `clk_out` and `locked` frozen, and the phase resumes where it left off.
  - Then load (1, 2) while running.
  - Required: `cfg_ready` = 0 for one cycle, `locked` clears, and the new period is 2.
- Asynchronous reset mid-run:
  - Assert `rst_n` between clock edges during 3/8 operation.
  - Required: outputs reset immediately, the block stays in IDLE after release, and it needs a new configuration to strobe again.
